mul_arbiter: RTL
================

// Module: mul_arbiter
// PURPOSE
//  Shares one sequential signed 16x16 multiply unit (start-pulse driven, no done flag) between
//  N_REQ requesters. Round-robin grant over valid/ready request ports; issues the start pulse,
//  counts the unit's fixed latency, captures the 32-bit product and returns it to the granted
//  requester on a valid/ready response channel. Sits between the client blocks and the multiplier.
// PARAMETERS
//  N_REQ        4   number of requesters (2..8)
//  OP_W         16  operand width, signed two's complement
//  MUL_LATENCY  34  cycles from the start-pulse cycle to a stable product (INIT + 16x2 + DONE)
// PORTS
//  clk           in   1            single clock, rising edge
//  rst           in   1            synchronous, active-high reset
//  req_valid     in   N_REQ        per-requester request valid
//  req_ready     out  N_REQ        one-hot grant/accept; only in IDLE
//  req_a         in   N_REQ*OP_W   multiplier operand, slice i = requester i
//  req_b         in   N_REQ*OP_W   multiplicand operand, slice i
//  resp_valid    out  N_REQ        one-hot; result ready for requester i
//  resp_ready    in   N_REQ        per-requester response accept
//  resp_product  out  2*OP_W       signed product (shared bus, qualified by resp_valid)
//  mul_start     out  1            one-cycle start pulse to multiply unit
//  mul_a         out  OP_W         registered multiplier to unit
//  mul_b         out  OP_W         registered multiplicand to unit
//  mul_product   in   2*OP_W       product from unit
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, counter=0; req_ready, resp_valid, mul_start=0;
//   mul_a, mul_b, resp_product=0. The multiply unit shares rst; an in-flight op is discarded.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: grant = first req_valid[i] searching from pointer upward, wrapping mod N_REQ;
//   req_ready = grant (combinational). On accept (valid&ready), latch a/b into mul_a/mul_b,
//   latch index, pointer <= index+1 mod N_REQ, go ISSUE. No valid -> stay, pointer unchanged.
//  ISSUE: mul_start=1 for exactly this cycle; counter <= MUL_LATENCY-1; go WAIT.
//  WAIT: counter decrements each cycle; at 0 capture mul_product into resp_product, go RESP.
//   Accept at cycle A -> resp_valid first high at cycle A+2+MUL_LATENCY.
//  RESP: resp_valid[index]=1, resp_product stable, held until resp_ready[index]; then IDLE.
//   resp_ready of other requesters ignored. New grant no earlier than the cycle after handoff.
//  mul_a/mul_b held constant from ISSUE through RESP (unit may sample any cycle).
//  req_valid/operand changes outside IDLE are ignored; a requester may drop valid before grant.
//  Simultaneous requests: exactly one granted per op; all valid requesters served within N_REQ
//   ops (no starvation). Single requester may be served back-to-back.
//  rst mid-WAIT/RESP: abandon op, no response, return to IDLE next cycle with pointer=0.
//  Widths: product is 2*OP_W signed, passed through unmodified; no saturation.
// STRUCTURE
//  Package mul_arb_pkg: FSM state enum (IDLE/ISSUE/WAIT/RESP), OP_W, MUL_LATENCY,
//   counter width localparam $clog2(MUL_LATENCY).
//  Sub-module rr_arbiter (N_REQ; in req, ptr; out one-hot grant, grant index), combinational.
//  Top holds FSM, latency counter, operand/result registers; multiply instantiated by parent.
// TESTING  (bench instantiates mul_arbiter + multiply, N_REQ=4)
//  1 Req0 only: a=3, b=4 -> resp_valid[0] at accept+36, resp_product=12, mul_start one cycle.
//  2 Req1 a=-42,b=-21; req3 a=9,b=-12 same cycle -> req1 served first (882), then req3 (-108).
//  3 All 4 valid continuously after reset -> grant order 0,1,2,3,0; no requester skipped.
//  4 Hold resp_ready[2]=0 for 10 cycles after a=-1,b=1 -> resp_valid[2], product=-1 stable,
//    no new grant until accept; resp_ready[0]=1 meanwhile has no effect.
//  5 Boundary a=-32768,b=-32768 -> 1073741824; a=-1,b=0 -> 0.
//  6 Assert rst mid-WAIT -> outputs zero next cycle, no response; fresh req a=5,b=6 -> 30.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiply-unit arbiter.
package mul_arb_pkg;
  localparam int OP_W        = 16;
  localparam int MUL_LATENCY = 34;
  localparam int CNT_W       = $clog2(MUL_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/mul_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);
  localparam int IW = $clog2(N_REQ);

  // Scan from the farthest offset down so the nearest hit to ptr is the last write.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end for one shared sequential signed multiplier with fixed latency.
module mul_arbiter #(
  parameter int N_REQ       = 4,
  parameter int OP_W        = mul_arb_pkg::OP_W,
  parameter int MUL_LATENCY = mul_arb_pkg::MUL_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0][OP_W-1:0] req_a,
  input  logic [N_REQ-1:0][OP_W-1:0] req_b,
  output logic [N_REQ-1:0]           resp_valid,
  input  logic [N_REQ-1:0]           resp_ready,
  output logic [2*OP_W-1:0]          resp_product,
  output logic                       mul_start,
  output logic [OP_W-1:0]            mul_a,
  output logic [OP_W-1:0]            mul_b,
  input  logic [2*OP_W-1:0]          mul_product
);
  import mul_arb_pkg::*;

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, idx, gidx;
  logic [N_REQ-1:0] grant;
  logic [CW-1:0]   cnt;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (resp_ready[idx]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    mul_start  = 1'b0;
    case (state)
      IDLE:    req_ready = grant;
      ISSUE:   mul_start = 1'b1;
      RESP:    resp_valid[idx] = 1'b1;
      default: ;
    endcase
  end

  // Operands stay put from ISSUE through RESP since the unit may sample them at any point.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      idx          <= '0;
      cnt          <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      resp_product <= '0;
    end else begin
      case (state)
        IDLE: if (|grant) begin
          mul_a <= req_a[gidx];
          mul_b <= req_b[gidx];
          idx   <= gidx;
          ptr   <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
        end
        ISSUE: cnt <= CW'(MUL_LATENCY - 1);
        WAIT: begin
          if (cnt == '0) resp_product <= mul_product;
          else           cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
